// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus bundle: ROM port, execute redirect and the decode handshake.
// master = fetch unit, slave = the ROM/execute/decode side.
interface instruction_fetch_unit_if;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        misaligned_err;
   logic [31:0] err_pc;

   modport master (
      output rom_addr, inst_valid, inst_data, inst_pc, misaligned_err, err_pc,
      input  rom_data, redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  rom_addr, inst_valid, inst_data, inst_pc, misaligned_err, err_pc,
      output rom_data, redirect_valid, redirect_pc, inst_ready
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// RV32E instruction fetch: owns the fetch PC, prefetches from a combinational ROM
// into a small queue, and handles execute redirects with a misaligned-target trap.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input logic                        clk,
   input logic                        reset,
   instruction_fetch_unit_if.master   bus
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [0:0] {RUN = 1'b0, HALT = 1'b1} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } entry_t;

   state_t             state_q, state_d;
   logic [31:0]        fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic               err_q, err_d;
   logic [31:0]        err_pc_q, err_pc_d;
   entry_t             mem_q [DEPTH];
   logic               deq;
   logic               enq;

   // Redirect beats everything; a full queue still enqueues when the head leaves.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      head_d     = head_q;
      tail_d     = tail_q;
      err_d      = err_q;
      err_pc_d   = err_pc_q;

      deq = (count_q != '0) & bus.inst_ready & ~bus.redirect_valid;
      enq = (state_q == RUN) & ~bus.redirect_valid &
            ((count_q < CNT_W'(DEPTH)) | deq);

      if (bus.redirect_valid) begin
         count_d = '0;
         head_d  = '0;
         tail_d  = '0;
         if (bus.redirect_pc[1:0] == 2'b00) begin
            fetch_pc_d = bus.redirect_pc;
            state_d    = RUN;
            err_d      = 1'b0;
         end else begin
            state_d  = HALT;
            err_d    = 1'b1;
            err_pc_d = bus.redirect_pc;
         end
      end else begin
         if (enq) begin
            tail_d     = tail_q + PTR_W'(1);
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (deq) begin
            head_d = head_q + PTR_W'(1);
         end
         if (enq && !deq) begin
            count_d = count_q + CNT_W'(1);
         end else if (deq && !enq) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         err_q      <= 1'b0;
         err_pc_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         err_q      <= err_d;
         err_pc_q   <= err_pc_d;
      end
   end

   // Entries are cleared on reset so the head reads as zero while reset is held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (enq) begin
         mem_q[tail_q] <= '{pc: fetch_pc_q, data: bus.rom_data};
      end
   end

   assign bus.rom_addr       = fetch_pc_q;
   assign bus.inst_valid     = (count_q != '0);
   assign bus.inst_data      = mem_q[head_q].data;
   assign bus.inst_pc        = mem_q[head_q].pc;
   assign bus.misaligned_err = err_q;
   assign bus.err_pc         = err_pc_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_instruction_fetch_unit;
   localparam int unsigned DEPTH   = 2;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

   logic clk = 1'b0;
   logic reset;
   logic rst_w;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   instruction_fetch_unit_if ifc ();
   instruction_fetch_unit_if ifw ();

   instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .bus(ifc.master)
   );

   instruction_fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_w (
      .clk(clk), .reset(rst_w), .bus(ifw.master)
   );

   // Program ROM: the function-call program words at known addresses, a hash elsewhere.
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      logic [31:0] w;
      case (a)
         32'h0000_0000: w = 32'h0640_0113;
         32'h0000_0004: w = 32'h0030_0513;
         32'h0000_0034: w = 32'hFFC1_0113;
         default:       w = {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
      endcase
      return w;
   endfunction

   always_comb ifc.rom_data = rom_word(ifc.rom_addr);
   always_comb ifw.rom_data = rom_word(ifw.rom_addr);

   // Reference model: next fetch address, queue of prefetched PCs, trap state.
   logic [31:0] m_pc;
   logic [31:0] m_q [$];
   bit          m_halt;
   bit          m_err;
   logic [31:0] m_err_pc;

   function automatic void model_reset();
      m_pc     = 32'h0;
      m_q.delete();
      m_halt   = 1'b0;
      m_err    = 1'b0;
      m_err_pc = 32'h0;
   endfunction

   function automatic void model_edge(input bit rv, input logic [31:0] rpc, input bit rdy);
      bit take;
      bit put;
      if (rv) begin
         m_q.delete();
         if (rpc[1:0] == 2'b00) begin
            m_pc   = rpc;
            m_halt = 1'b0;
            m_err  = 1'b0;
         end else begin
            m_halt   = 1'b1;
            m_err    = 1'b1;
            m_err_pc = rpc;
         end
      end else begin
         take = (m_q.size() != 0) && rdy;
         put  = !m_halt && ((m_q.size() < int'(DEPTH)) || take);
         if (take) void'(m_q.pop_front());
         if (put) begin
            m_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
         end
      end
   endfunction

   task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
      ifc.redirect_valid = rv;
      ifc.redirect_pc    = rpc;
      ifc.inst_ready     = rdy;
      @(posedge clk);
      model_edge(rv, rpc, rdy);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ifc.redirect_valid = 1'b0;
      ifc.redirect_pc    = 32'h0;
      ifc.inst_ready     = 1'b1;
      model_reset();
      #1;
      checks++; if (ifc.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ifc.inst_valid); end
      checks++; if (ifc.inst_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", ifc.inst_data); end
      checks++; if (ifc.inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", ifc.inst_pc); end
      checks++; if (ifc.rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr got=%h exp=0", ifc.rom_addr); end
      checks++; if (ifc.misaligned_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", ifc.misaligned_err); end
      checks++; if (ifc.err_pc !== 32'h0) begin errors++; $display("FAIL reset_err_pc got=%h exp=0", ifc.err_pc); end
      checks++; if (ifw.rom_addr !== WRAP_PC) begin errors++; $display("FAIL reset_wrap_rom_addr got=%h exp=%h", ifw.rom_addr, WRAP_PC); end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_stream();
      logic [31:0] exp;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 32'h0, 1'b1);
         exp = 32'(4 * i);
         checks++;
         if (ifc.inst_valid !== 1'b1 || ifc.inst_pc !== exp) begin
            errors++; $display("FAIL stream_pc[%0d] got=%b/%h exp=1/%h", i, ifc.inst_valid, ifc.inst_pc, exp);
         end
         checks++;
         if (ifc.inst_data !== rom_word(exp)) begin
            errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, ifc.inst_data, rom_word(exp));
         end
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 32'h0, 1'b0);
         if (i >= 1) begin
            checks++;
            if (ifc.rom_addr !== 32'h8 || ifc.inst_pc !== 32'h0 || ifc.inst_valid !== 1'b1) begin
               errors++; $display("FAIL bp_hold[%0d] got addr=%h pc=%h v=%b exp addr=8 pc=0 v=1", i, ifc.rom_addr, ifc.inst_pc, ifc.inst_valid);
            end
         end
      end
      ifc.inst_ready = 1'b1;
      #1;
      checks++; if (ifc.inst_pc !== 32'h0) begin errors++; $display("FAIL bp_release_head got=%h exp=0", ifc.inst_pc); end
      for (int i = 1; i < 4; i++) begin
         step(1'b0, 32'h0, 1'b1);
         checks++;
         if (ifc.inst_valid !== 1'b1 || ifc.inst_pc !== 32'(4 * i)) begin
            errors++; $display("FAIL bp_release[%0d] got=%b/%h exp=1/%h", i, ifc.inst_valid, ifc.inst_pc, 32'(4 * i));
         end
      end
   endtask

   task automatic test_redirect_full();
      logic [31:0] old_head;
      step(1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      old_head = m_q[0];
      step(1'b1, 32'h34, 1'b1);
      checks++;
      if (ifc.inst_valid !== 1'b0 || ifc.rom_addr !== 32'h34) begin
         errors++; $display("FAIL redir_flush got v=%b addr=%h exp v=0 addr=34", ifc.inst_valid, ifc.rom_addr);
      end
      step(1'b0, 32'h0, 1'b1);
      checks++;
      if (ifc.inst_valid !== 1'b1 || ifc.inst_pc !== 32'h34 || ifc.inst_data !== 32'hFFC1_0113) begin
         errors++; $display("FAIL redir_target got v=%b pc=%h d=%h exp v=1 pc=34 d=ffc10113", ifc.inst_valid, ifc.inst_pc, ifc.inst_data);
      end
      step(1'b0, 32'h0, 1'b1);
      checks++;
      if (ifc.inst_pc !== 32'h38 || ifc.inst_pc === old_head) begin
         errors++; $display("FAIL redir_next got=%h exp=38 (discarded %h)", ifc.inst_pc, old_head);
      end
   endtask

   task automatic test_misaligned();
      logic [31:0] held;
      held = m_pc;
      step(1'b1, 32'h36, 1'b1);
      checks++;
      if (ifc.misaligned_err !== 1'b1 || ifc.err_pc !== 32'h36 || ifc.inst_valid !== 1'b0 || ifc.rom_addr !== held) begin
         errors++; $display("FAIL mis_trap got err=%b epc=%h v=%b addr=%h exp 1/36/0/%h", ifc.misaligned_err, ifc.err_pc, ifc.inst_valid, ifc.rom_addr, held);
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 32'h0, 1'b1);
         checks++;
         if (ifc.inst_valid !== 1'b0 || ifc.rom_addr !== held || ifc.misaligned_err !== 1'b1) begin
            errors++; $display("FAIL mis_halt[%0d] got v=%b addr=%h err=%b exp 0/%h/1", i, ifc.inst_valid, ifc.rom_addr, ifc.misaligned_err, held);
         end
      end
      step(1'b1, 32'h41, 1'b1);
      checks++;
      if (ifc.misaligned_err !== 1'b1 || ifc.err_pc !== 32'h41 || ifc.inst_valid !== 1'b0) begin
         errors++; $display("FAIL mis_again got err=%b epc=%h v=%b exp 1/41/0", ifc.misaligned_err, ifc.err_pc, ifc.inst_valid);
      end
      step(1'b1, 32'h10, 1'b1);
      checks++;
      if (ifc.misaligned_err !== 1'b0 || ifc.inst_valid !== 1'b0 || ifc.rom_addr !== 32'h10) begin
         errors++; $display("FAIL mis_recover got err=%b v=%b addr=%h exp 0/0/10", ifc.misaligned_err, ifc.inst_valid, ifc.rom_addr);
      end
      step(1'b0, 32'h0, 1'b1);
      checks++;
      if (ifc.inst_valid !== 1'b1 || ifc.inst_pc !== 32'h10 || ifc.inst_data !== rom_word(32'h10)) begin
         errors++; $display("FAIL mis_resume got v=%b pc=%h d=%h exp 1/10/%h", ifc.inst_valid, ifc.inst_pc, ifc.inst_data, rom_word(32'h10));
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
      checks++; if (ifc.inst_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got v=%b exp 1", ifc.inst_valid); end
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if (ifc.inst_valid !== 1'b0 || ifc.rom_addr !== 32'h0 || ifc.inst_pc !== 32'h0 || ifc.inst_data !== 32'h0) begin
         errors++; $display("FAIL areset_now got v=%b addr=%h pc=%h d=%h exp all 0", ifc.inst_valid, ifc.rom_addr, ifc.inst_pc, ifc.inst_data);
      end
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b0, 32'h0, 1'b1);
      checks++;
      if (ifc.inst_valid !== 1'b1 || ifc.inst_pc !== 32'h0 || ifc.inst_data !== 32'h0640_0113) begin
         errors++; $display("FAIL areset_restart got v=%b pc=%h d=%h exp 1/0/06400113", ifc.inst_valid, ifc.inst_pc, ifc.inst_data);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_w [4];
      exp_w[0] = 32'hFFFF_FFF8;
      exp_w[1] = 32'hFFFF_FFFC;
      exp_w[2] = 32'h0000_0000;
      exp_w[3] = 32'h0000_0004;
      rst_w = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 32'h0, 1'b1);
         checks++;
         if (ifw.inst_valid !== 1'b1 || ifw.inst_pc !== exp_w[i] || ifw.inst_data !== rom_word(exp_w[i])) begin
            errors++; $display("FAIL wrap[%0d] got v=%b pc=%h d=%h exp 1/%h/%h", i, ifw.inst_valid, ifw.inst_pc, ifw.inst_data, exp_w[i], rom_word(exp_w[i]));
         end
      end
   endtask

   task automatic test_random();
      bit          rv;
      bit          rdy;
      logic [31:0] rpc;
      for (int i = 0; i < 500; i++) begin
         rdy = ($urandom_range(0, 9) < 7);
         rv  = ($urandom_range(0, 19) == 0);
         rpc = 32'($urandom_range(0, 31)) << 2;
         if ($urandom_range(0, 3) == 0) rpc = rpc | 32'($urandom_range(1, 3));
         step(rv, rpc, rdy);
         checks++;
         if (ifc.inst_valid !== (m_q.size() != 0)) begin
            errors++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, ifc.inst_valid, (m_q.size() != 0));
         end
         if (m_q.size() != 0) begin
            checks++;
            if (ifc.inst_pc !== m_q[0] || ifc.inst_data !== rom_word(m_q[0])) begin
               errors++; $display("FAIL rnd_head[%0d] got pc=%h d=%h exp pc=%h d=%h", i, ifc.inst_pc, ifc.inst_data, m_q[0], rom_word(m_q[0]));
            end
         end
         checks++;
         if (ifc.rom_addr !== m_pc) begin
            errors++; $display("FAIL rnd_rom_addr[%0d] got=%h exp=%h", i, ifc.rom_addr, m_pc);
         end
         checks++;
         if (ifc.misaligned_err !== m_err || ifc.err_pc !== m_err_pc) begin
            errors++; $display("FAIL rnd_err[%0d] got=%b/%h exp=%b/%h", i, ifc.misaligned_err, ifc.err_pc, m_err, m_err_pc);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      rst_w = 1'b1;
      ifw.redirect_valid = 1'b0;
      ifw.redirect_pc    = 32'h0;
      ifw.inst_ready     = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_full();
      test_misaligned();
      test_async_reset();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Sequences the combinational program ROM for the RV32E core.
- Owns the fetch PC, drives the ROM address, and buffers fetched words with their PCs in a small prefetch queue.
- Presents instructions to decode over a valid/ready handshake.
- Accepts redirects (JAL/JALR/branch taken) from execute; flushes stale prefetches and traps misaligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset; must be 4-byte aligned.
- DEPTH, 2, prefetch queue entries; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rom_addr  output  32  byte address to program ROM; equals the fetch_pc register.
- rom_data  input  32  ROM word for rom_addr; combinational, valid in the same cycle.
- redirect_valid  input  1  single-cycle request to restart fetch at redirect_pc.
- redirect_pc  input  32  redirect target byte address.
- inst_valid  output  1  queue head holds an instruction.
- inst_ready  input  1  decode accepts the head this cycle.
- inst_data  output  32  instruction word at queue head.
- inst_pc  output  32  byte address of inst_data.
- misaligned_err  output  1  sticky flag: last redirect target had pc[1:0] != 0.
- err_pc  output  32  the offending redirect_pc captured with misaligned_err.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - fetch_pc = RESET_PC; queue count = 0, head and tail pointers = 0.
  - state = RUN; misaligned_err = 0; err_pc = 0.
  - Outputs during reset: inst_valid = 0, inst_data = 0, inst_pc = 0, rom_addr = RESET_PC.
- States: RUN (fetching) and HALT (misaligned trap, no fetching).
- Handshake terms:
  - deq = inst_valid & inst_ready & !redirect_valid.
  - enq = (state == RUN) & !redirect_valid & (count < DEPTH | deq).
  - A full queue with a simultaneous deq still enqueues, giving no bubble.
- On enq: write {fetch_pc, rom_data} at tail; fetch_pc += 4. The 32-bit add wraps, so 0xFFFF_FFFC goes to 0.
- Count update: +1 on enq only, -1 on deq only, unchanged on both or neither.
- Queue outputs:
  - inst_valid = (count != 0); inst_data and inst_pc come from the head entry.
  - Head fields are stable while inst_valid & !inst_ready.
- Redirect has highest priority:
  - On the edge where redirect_valid = 1: count = 0, pointers = 0, and any simultaneous inst handshake is discarded (not consumed).
  - Aligned redirect (redirect_pc[1:0] == 0): fetch_pc = redirect_pc; state = RUN; misaligned_err = 0.
  - Misaligned redirect: fetch_pc unchanged; state = HALT; misaligned_err = 1; err_pc = redirect_pc.
- Latency:
  - After reset deasserts, the first rising edge enqueues RESET_PC, so inst_valid = 1 after 1 edge.
  - Redirect penalty is 2 edges. Edge 1 flushes and loads fetch_pc. Edge 2 enqueues the target, so inst_valid = 1 with inst_pc = target after edge 2.
- HALT:
  - No enq; inst_valid = 0; rom_addr holds.
  - Exits only via an aligned redirect (to RUN) or reset. A further misaligned redirect stays in HALT and updates err_pc.
- Throughput with inst_ready held at 1: one instruction per cycle, PCs strictly consecutive, no duplicates or gaps.
- Empty-queue boundary: deq is impossible when count = 0, so there is no underflow and no bypass from rom_data to inst_data. Minimum latency from enqueue to presentation is 1 edge.

Test Plan:
- Reset release with inst_ready = 1 and the function-call program in ROM:
  - Edge 1: inst_pc = 0x0, inst_data = 0x06400113.
  - Edge 2: inst_pc = 0x4, inst_data = 0x00300513.
  - Edge 3: inst_pc = 0x8.
  - Then +4 every cycle.
- Backpressure, inst_ready = 0 for 6 cycles after reset:
  - count saturates at DEPTH = 2; rom_addr holds at 0x8; inst_pc stays 0x0.
  - On release, inst_pc runs 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- Redirect to 0x34 while the queue is full and inst_ready = 1 in the same cycle:
  - Next cycle: inst_valid = 0, rom_addr = 0x34.
  - Following cycle: inst_pc = 0x34, inst_data = 0xFFC10113.
  - The discarded head never reappears.
- Misaligned redirect to 0x36:
  - misaligned_err = 1, err_pc = 0x36; inst_valid stays 0 for 10 cycles; rom_addr is unchanged.
  - Then redirect to 0x10: misaligned_err = 0, and 2 edges later inst_pc = 0x10.
- Asynchronous reset pulse asserted between clock edges mid-stream:
  - inst_valid = 0 and rom_addr = RESET_PC immediately, before the next edge.
  - After release, fetch restarts at 0x0.
- RESET_PC = 0xFFFF_FFF8, inst_ready = 1: inst_pc sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
